// File: rtl/xc20xx_cfg_loader.sv
// Serial configuration loader for the XC20XX CLB array: syncs on an XC2064-style
// preamble, reads a length count, then emits one parallel CLB config word per framed record.
module xc20xx_cfg_loader #(
   parameter int FRAME_BITS = 24,
   parameter int NUM_FRAMES = 4,
   parameter int LEN_BITS   = 24,
   parameter int ADDR_W     = 2
) (
   input  logic                  K,
   input  logic                  RST,
   input  logic                  DIN,
   output logic [FRAME_BITS-1:0] CFG_DATA,
   output logic [ADDR_W-1:0]     CFG_ADDR,
   output logic                  CFG_WE,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  ERR
);

   localparam int MAX_FIELD = (LEN_BITS > FRAME_BITS) ? LEN_BITS : FRAME_BITS;
   localparam int CW        = $clog2(MAX_FIELD);
   localparam int CNT_W     = $clog2(NUM_FRAMES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_HDR, S_START, S_DATA, S_STOP, S_DONE, S_ERR
   } state_t;

   state_t                state;
   logic [3:0]            hist;
   logic [2:0]            hist_n;
   logic [LEN_BITS-1:0]   len;
   logic [CW-1:0]         bit_cnt;
   logic [FRAME_BITS-1:0] shreg;
   logic [CNT_W-1:0]      fcnt;
   logic                  wr_pend;
   logic                  last_pend;

   logic [3:0]            hist_next;
   logic [LEN_BITS-1:0]   len_next;
   logic [FRAME_BITS-1:0] frame_next;

   assign hist_next  = {hist[2:0], DIN};
   assign len_next   = {len[LEN_BITS-2:0], DIN};
   assign frame_next = {shreg[FRAME_BITS-2:0], DIN};

   // hist_n counts valid history bits so reset-cleared zeros never look like preamble bits.
   // A completed frame is strobed one edge after its last stop bit, while the next
   // start bit is being sampled; the data shifter is untouched during that bit.
   always_ff @(posedge K or posedge RST) begin
      if (RST) begin
         state     <= S_IDLE;
         hist      <= '0;
         hist_n    <= '0;
         len       <= '0;
         bit_cnt   <= '0;
         shreg     <= '0;
         fcnt      <= '0;
         wr_pend   <= 1'b0;
         last_pend <= 1'b0;
         CFG_DATA  <= '0;
         CFG_ADDR  <= '0;
         CFG_WE    <= 1'b0;
         BUSY      <= 1'b0;
         DONE      <= 1'b0;
         ERR       <= 1'b0;
      end else begin
         CFG_WE <= 1'b0;
         if (wr_pend) begin
            CFG_WE   <= 1'b1;
            CFG_DATA <= shreg;
            CFG_ADDR <= fcnt[ADDR_W-1:0];
            fcnt     <= fcnt + CNT_W'(1);
            wr_pend  <= 1'b0;
            if (last_pend) begin
               DONE <= 1'b1;
               BUSY <= 1'b0;
            end
         end
         case (state)
            S_IDLE: begin
               hist <= hist_next;
               if (hist_n != 3'd4) hist_n <= hist_n + 3'd1;
               if (hist_n >= 3'd3 && hist_next == 4'b0010) begin
                  state   <= S_LEN;
                  BUSY    <= 1'b1;
                  bit_cnt <= '0;
                  len     <= '0;
               end else begin
                  BUSY <= !DIN || (hist_n >= 3'd2 && hist_next[2:0] == 3'b001);
               end
            end
            S_LEN: begin
               len     <= len_next;
               bit_cnt <= bit_cnt + CW'(1);
               if (bit_cnt == CW'(LEN_BITS - 1)) begin
                  bit_cnt <= '0;
                  if (len_next == '0 || len_next > LEN_BITS'(NUM_FRAMES)) begin
                     state <= S_ERR;
                     ERR   <= 1'b1;
                     BUSY  <= 1'b0;
                  end else begin
                     state <= S_HDR;
                  end
               end
            end
            S_HDR: begin
               if (!DIN) begin
                  state <= S_ERR;
                  ERR   <= 1'b1;
                  BUSY  <= 1'b0;
               end else if (bit_cnt == CW'(3)) begin
                  state   <= S_START;
                  bit_cnt <= '0;
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end
            S_START: begin
               if (DIN) begin
                  state <= S_ERR;
                  ERR   <= 1'b1;
                  BUSY  <= 1'b0;
               end else begin
                  state   <= S_DATA;
                  bit_cnt <= '0;
               end
            end
            S_DATA: begin
               shreg <= frame_next;
               if (bit_cnt == CW'(FRAME_BITS - 1)) begin
                  state   <= S_STOP;
                  bit_cnt <= '0;
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end
            S_STOP: begin
               if (!DIN) begin
                  state <= S_ERR;
                  ERR   <= 1'b1;
                  BUSY  <= 1'b0;
               end else if (bit_cnt == CW'(2)) begin
                  bit_cnt   <= '0;
                  wr_pend   <= 1'b1;
                  last_pend <= (LEN_BITS'(fcnt) + LEN_BITS'(1)) == len;
                  state     <= ((LEN_BITS'(fcnt) + LEN_BITS'(1)) == len) ? S_DONE : S_START;
               end else begin
                  bit_cnt <= bit_cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_xc20xx_cfg_loader.sv
// Directed bench for xc20xx_cfg_loader: drives bitstreams on DIN and checks strobes,
// addresses, data words and status flags against hand-computed values.
module tb_xc20xx_cfg_loader;

   logic        K = 1'b0;
   logic        RST = 1'b0;
   logic        DIN = 1'b1;
   logic [23:0] CFG_DATA;
   logic [1:0]  CFG_ADDR;
   logic        CFG_WE;
   logic        BUSY;
   logic        DONE;
   logic        ERR;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   logic [31:0] we_addr[$];
   logic [31:0] we_data[$];
   logic [31:0] we_cyc[$];
   logic [31:0] we_done[$];

   xc20xx_cfg_loader #(
      .FRAME_BITS(24), .NUM_FRAMES(4), .LEN_BITS(24), .ADDR_W(2)
   ) dut (
      .K(K), .RST(RST), .DIN(DIN),
      .CFG_DATA(CFG_DATA), .CFG_ADDR(CFG_ADDR), .CFG_WE(CFG_WE),
      .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
   );

   always #5 K = ~K;

   always @(posedge K) cyc <= cyc + 1;

   // Every sampled strobe cycle is logged, so a strobe held for two cycles shows up as an extra write.
   always @(negedge K) begin
      if (CFG_WE === 1'b1) begin
         we_addr.push_back(32'(CFG_ADDR));
         we_data.push_back(32'(CFG_DATA));
         we_cyc.push_back(32'(cyc));
         we_done.push_back(32'(DONE));
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] q_at(input logic [31:0] q[$], input int idx);
      return (idx < q.size()) ? q[idx] : 32'hDEAD_BEEF;
   endfunction

   task automatic send_bit(input logic b);
      @(negedge K);
      DIN = b;
   endtask

   task automatic applyStimulus(input logic [31:0] value, input int nbits);
      for (int i = nbits - 1; i >= 0; i--) send_bit(value[i]);
   endtask

   task automatic send_preamble();
      applyStimulus(32'hF, 4);
      applyStimulus(32'b0010, 4);
   endtask

   task automatic send_frame(input logic [31:0] data, input logic [2:0] stop);
      send_bit(1'b0);
      applyStimulus(data, 24);
      applyStimulus(32'(stop), 3);
   endtask

   task automatic tail(input int n);
      repeat (n) send_bit(1'b1);
      @(negedge K);
   endtask

   task automatic clear_log();
      we_addr.delete();
      we_data.delete();
      we_cyc.delete();
      we_done.delete();
   endtask

   task automatic do_reset(input string tag);
      @(negedge K);
      RST = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge K);
         DIN = ~DIN;
      end
      #1;
      checkOutput({tag, "_data"}, 32'(CFG_DATA), 32'h0);
      checkOutput({tag, "_addr"}, 32'(CFG_ADDR), 32'h0);
      checkOutput({tag, "_we"},   32'(CFG_WE),   32'h0);
      checkOutput({tag, "_busy"}, 32'(BUSY),     32'h0);
      checkOutput({tag, "_done"}, 32'(DONE),     32'h0);
      checkOutput({tag, "_err"},  32'(ERR),      32'h0);
      @(negedge K);
      DIN = 1'b1;
      RST = 1'b0;
   endtask

   initial begin
      // 1. reset and idle line
      $display("[TB] reset and idle");
      do_reset("rst0");
      tail(20);
      checkOutput("idle_busy", 32'(BUSY), 32'h0);
      checkOutput("idle_nowe", 32'(we_addr.size()), 32'h0);

      // 2. good two-frame load
      $display("[TB] good load");
      send_preamble();
      applyStimulus(32'd2, 24);
      checkOutput("load_busy", 32'(BUSY), 32'h1);
      applyStimulus(32'hF, 4);
      send_frame(32'h2A55C3, 3'b111);
      send_frame(32'h0000FF, 3'b111);
      tail(4);
      checkOutput("load_cnt",   32'(we_addr.size()), 32'd2);
      checkOutput("load_a0",    q_at(we_addr, 0), 32'd0);
      checkOutput("load_d0",    q_at(we_data, 0), 32'h2A55C3);
      checkOutput("load_done0", q_at(we_done, 0), 32'd0);
      checkOutput("load_a1",    q_at(we_addr, 1), 32'd1);
      checkOutput("load_d1",    q_at(we_data, 1), 32'h0000FF);
      checkOutput("load_done1", q_at(we_done, 1), 32'd1);
      checkOutput("load_space", q_at(we_cyc, 1) - q_at(we_cyc, 0), 32'd28);
      checkOutput("load_hold_d", 32'(CFG_DATA), 32'h0000FF);
      checkOutput("load_hold_a", 32'(CFG_ADDR), 32'd1);
      checkOutput("load_done",   32'(DONE), 32'h1);
      checkOutput("load_err",    32'(ERR),  32'h0);
      checkOutput("load_idle",   32'(BUSY), 32'h0);

      // 3a. zero length
      $display("[TB] length and header errors");
      do_reset("rst1");
      clear_log();
      send_preamble();
      applyStimulus(32'd0, 24);
      checkOutput("len0_pre", 32'(ERR), 32'h0);
      send_bit(1'b1);
      checkOutput("len0_err", 32'(ERR), 32'h1);
      applyStimulus(32'hF, 3);
      send_frame(32'h123456, 3'b111);
      tail(4);
      checkOutput("len0_busy", 32'(BUSY), 32'h0);
      checkOutput("len0_done", 32'(DONE), 32'h0);
      checkOutput("len0_nowe", 32'(we_addr.size()), 32'h0);

      // 3b. length above frame capacity, then exactly at capacity
      do_reset("rst2");
      send_preamble();
      applyStimulus(32'd5, 24);
      send_bit(1'b1);
      checkOutput("len5_err", 32'(ERR), 32'h1);
      do_reset("rst3");
      send_preamble();
      applyStimulus(32'd4, 24);
      applyStimulus(32'hF, 4);
      tail(0);
      checkOutput("len4_err",  32'(ERR),  32'h0);
      checkOutput("len4_busy", 32'(BUSY), 32'h1);

      // 3c. bad header bit
      do_reset("rst4");
      clear_log();
      send_preamble();
      applyStimulus(32'd1, 24);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      checkOutput("hdr_pre", 32'(ERR), 32'h0);
      send_bit(1'b1);
      checkOutput("hdr_err", 32'(ERR), 32'h1);
      send_frame(32'h654321, 3'b111);
      tail(4);
      checkOutput("hdr_nowe", 32'(we_addr.size()), 32'h0);

      // 4. bad stop bit on second frame
      $display("[TB] stop-bit error");
      do_reset("rst5");
      clear_log();
      send_preamble();
      applyStimulus(32'd2, 24);
      applyStimulus(32'hF, 4);
      send_frame(32'h123456, 3'b111);
      send_bit(1'b0);
      applyStimulus(32'hABCDEF, 24);
      send_bit(1'b1);
      send_bit(1'b0);
      checkOutput("stop_pre", 32'(ERR), 32'h0);
      send_bit(1'b1);
      checkOutput("stop_err", 32'(ERR), 32'h1);
      tail(4);
      checkOutput("stop_cnt",  32'(we_addr.size()), 32'd1);
      checkOutput("stop_a0",   q_at(we_addr, 0), 32'd0);
      checkOutput("stop_d0",   q_at(we_data, 0), 32'h123456);
      checkOutput("stop_done", 32'(DONE), 32'h0);
      checkOutput("stop_busy", 32'(BUSY), 32'h0);

      // 5. reset in the middle of frame 1, then restream
      $display("[TB] reset mid-frame");
      do_reset("rst6");
      clear_log();
      send_preamble();
      applyStimulus(32'd2, 24);
      applyStimulus(32'hF, 4);
      send_frame(32'hABCDEF, 3'b111);
      send_bit(1'b0);
      applyStimulus(32'h3FF, 10);
      do_reset("rst7");
      tail(30);
      checkOutput("mid_cnt", 32'(we_addr.size()), 32'd1);
      checkOutput("mid_d0",  q_at(we_data, 0), 32'hABCDEF);
      clear_log();
      send_preamble();
      applyStimulus(32'd1, 24);
      applyStimulus(32'hF, 4);
      send_frame(32'h0F0F0F, 3'b111);
      tail(4);
      checkOutput("re_cnt",  32'(we_addr.size()), 32'd1);
      checkOutput("re_a0",   q_at(we_addr, 0), 32'd0);
      checkOutput("re_d0",   q_at(we_data, 0), 32'h0F0F0F);
      checkOutput("re_done", 32'(DONE), 32'h1);

      // 6. traffic after DONE is ignored; garbage before a preamble
      $display("[TB] post-done and garbage sync");
      clear_log();
      send_preamble();
      applyStimulus(32'd1, 24);
      applyStimulus(32'hF, 4);
      send_frame(32'h777777, 3'b111);
      tail(4);
      checkOutput("post_nowe", 32'(we_addr.size()), 32'h0);
      checkOutput("post_done", 32'(DONE), 32'h1);
      checkOutput("post_err",  32'(ERR),  32'h0);
      do_reset("rst8");
      clear_log();
      applyStimulus(32'hF, 4);
      applyStimulus(32'b0110010, 7);
      applyStimulus(32'd1, 24);
      applyStimulus(32'hF, 4);
      send_frame(32'h3C3C3C, 3'b111);
      tail(4);
      checkOutput("garb_cnt",  32'(we_addr.size()), 32'd1);
      checkOutput("garb_a0",   q_at(we_addr, 0), 32'd0);
      checkOutput("garb_d0",   q_at(we_data, 0), 32'h3C3C3C);
      checkOutput("garb_done", 32'(DONE), 32'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
